// File: rtl/note_pkg.sv
// note_pkg: game state encoding and default parameter values shared by the
// note_lane_engine top and its note_lane rows.
package note_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam int LANES_DEF      = 5;
   localparam int DEPTH_DEF      = 12;
   localparam int LIVES_INIT_DEF = 5;
   localparam int MULT_MAX_DEF   = 4;
   localparam int SCORE_W_DEF    = 10;

endpackage

// File: rtl/note_lane.sv
// note_lane: one DEPTH-row falling-note lane. Row 0 is the spawn row and
// row DEPTH-1 is the hit row. A hit clears the bottom row before any shift
// in the same cycle, so a hit note never shows up as a falloff.
module note_lane #(
   parameter int DEPTH = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             tick,
   input  logic             spawn,
   input  logic             hit_clr,
   output logic [DEPTH-1:0] bits,
   output logic             falloff
);

   logic [DEPTH-1:0] bits_q;
   logic [DEPTH-1:0] kept;

   // Lane contents after removing a note that was hit this cycle.
   always_comb begin
      kept = bits_q;
      if (hit_clr) begin
         kept[DEPTH-1] = 1'b0;
      end
   end

   // Row storage: cleared on game start, shifted toward the hit row on tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bits_q <= '0;
      end else if (clear) begin
         bits_q <= '0;
      end else if (tick) begin
         bits_q <= {kept[DEPTH-2:0], spawn};
      end else begin
         bits_q <= kept;
      end
   end

   assign falloff = tick & kept[DEPTH-1];
   assign bits    = bits_q;

endmodule

// File: rtl/note_lane_engine.sv
// note_lane_engine: rhythm-game core. LANES falling-note lanes, key
// judgement on the bottom row, saturating score with a hit multiplier,
// and a lives counter driving an IDLE/PLAY/OVER game FSM.
// Build option: define NOTE_LANE_ENGINE_FALLOFF_MISS_EN to make a note that
// falls off the bottom row unhit cost a life; otherwise it is dropped silently.
module note_lane_engine
   import note_pkg::*;
#(
   parameter int LANES      = LANES_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int LIVES_INIT = LIVES_INIT_DEF,
   parameter int MULT_MAX   = MULT_MAX_DEF,
   parameter int SCORE_W    = SCORE_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     tick,
   input  logic                     spawn_valid,
   input  logic [$clog2(LANES)-1:0] spawn_lane,
   input  logic [LANES-1:0]         key_press,
   output logic [LANES*DEPTH-1:0]   lane_bits,
   output logic [SCORE_W-1:0]       score,
   output logic [3:0]               lives,
   output logic [2:0]               mult,
   output logic                     hit_pulse,
   output logic                     miss_pulse,
   output logic                     game_over
);

   localparam int SLW   = $clog2(LANES);
   localparam int SUM_W = SCORE_W + 7;

`ifdef NOTE_LANE_ENGINE_FALLOFF_MISS_EN
   localparam bit FALLOFF_MISS = 1'b1;
`else
   localparam bit FALLOFF_MISS = 1'b0;
`endif

   state_t               state_q;
   state_t               state_n;
   logic                 play;
   logic                 start_clear;
   logic                 lane_tick;
   logic [LANES-1:0]     hit;
   logic [LANES-1:0]     wrong;
   logic [LANES-1:0]     falloff;
   logic [LANES-1:0]     lane_spawn;
   logic [3:0]           hit_cnt;
   logic                 miss_evt;
   logic [SUM_W-1:0]     sum;
   logic [SCORE_W-1:0]   score_q;
   logic [SCORE_W-1:0]   score_n;
   logic [3:0]           lives_q;
   logic [2:0]           mult_q;
   logic [2:0]           mult_n;
   logic                 hit_pulse_q;
   logic                 miss_pulse_q;

   assign play      = (state_q == PLAY);
   assign lane_tick = play & tick;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam logic [SLW-1:0] LANE_ID = SLW'(l);
      logic [DEPTH-1:0] row_bits;

      assign hit[l]        = play & key_press[l] &  row_bits[DEPTH-1];
      assign wrong[l]      = play & key_press[l] & ~row_bits[DEPTH-1];
      assign lane_spawn[l] = lane_tick & spawn_valid & (spawn_lane == LANE_ID);

      note_lane #(
         .DEPTH (DEPTH)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .clear   (start_clear),
         .tick    (lane_tick),
         .spawn   (lane_spawn[l]),
         .hit_clr (hit[l]),
         .bits    (row_bits),
         .falloff (falloff[l])
      );

      assign lane_bits[l*DEPTH +: DEPTH] = row_bits;
   end

   // Judgement: count hits, detect a miss event, compute next score and multiplier.
   // The score add uses the multiplier in effect before this cycle's update.
   always_comb begin
      hit_cnt = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         hit_cnt = hit_cnt + 4'(hit[i]);
      end
      miss_evt = (|wrong) | (FALLOFF_MISS & (|falloff));
      sum      = SUM_W'(score_q) + SUM_W'(hit_cnt) * SUM_W'(mult_q);
      score_n  = (|sum[SUM_W-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
      mult_n   = mult_q;
      if (miss_evt) begin
         mult_n = 3'd1;
      end else if (hit_cnt != '0) begin
         mult_n = (mult_q >= 3'(MULT_MAX)) ? 3'(MULT_MAX) : mult_q + 3'd1;
      end
   end

   // Next-state logic: start enters PLAY from IDLE or OVER; losing the last life ends the game.
   always_comb begin
      state_n     = state_q;
      start_clear = 1'b0;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_n     = PLAY;
               start_clear = 1'b1;
            end
         end
         PLAY: begin
            if (miss_evt && lives_q <= 4'd1) begin
               state_n = OVER;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Game state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Score, lives, multiplier and judgement strobes; all frozen outside PLAY.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score_q      <= '0;
         lives_q      <= 4'(LIVES_INIT);
         mult_q       <= 3'd1;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
      end else begin
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         if (start_clear) begin
            score_q <= '0;
            lives_q <= 4'(LIVES_INIT);
            mult_q  <= 3'd1;
         end else if (play) begin
            score_q      <= score_n;
            mult_q       <= mult_n;
            hit_pulse_q  <= (hit_cnt != '0);
            miss_pulse_q <= miss_evt;
            if (miss_evt) begin
               lives_q <= lives_q - 4'd1;
            end
         end
      end
   end

   assign score      = score_q;
   assign lives      = lives_q;
   assign mult       = mult_q;
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;
   assign game_over  = (state_q == OVER);

endmodule
